float_div_seq: RTL and testbench



---
 rtl/float_div_seq.sv | 269 ++++++++++++++++++++++++++
 tb/tb_float_div_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/float_div_seq.sv
// ---------------------------------------------------------------------------
// float_div_seq
//   Iterative floating-point divider (a / b). It uses a radix-2 restoring
//   mantissa divider and round-to-nearest-even, and it raises IEEE exception
//   flags. Subnormal inputs are flushed to signed zero. Results too small
//   for a normal number underflow to signed zero.
//
// Handshakes (same rule on both sides):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. Once valid is raised, the data under it stays stable until that
//   transfer happens.
//   Input side:  in_valid / in_ready. in_ready is high only in IDLE.
//   Output side: out_valid / out_ready. out_valid is high only in DONE.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands present on a/b
//   in_ready   divider idle and able to accept operands
//   a, b       dividend / divisor, W = 1+EXP_W+MAN_W bits
//   out_valid  result/flags present
//   out_ready  consumer takes result
//   result     quotient
//   flags      {invalid, div_by_zero, overflow, underflow, inexact}
//   state_o    current FSM state, for debug/observation
// ---------------------------------------------------------------------------
module float_div_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [4:0]   flags,
    output logic [2:0]   state_o
);

    localparam int EW    = EXP_W + 2;              // signed working exponent
    localparam int CNT_W = $clog2(MAN_W + 3);

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EW-1:0]    BIAS_E   = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0]    EMAX     = EW'((1 << EXP_W) - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAN_W + 2);
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [4:0] FL_INV = 5'b10000;
    localparam logic [4:0] FL_DBZ = 5'b01000;
    localparam logic [4:0] FL_OVF = 5'b00100;
    localparam logic [4:0] FL_UNF = 5'b00010;
    localparam logic [4:0] FL_INX = 5'b00001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_DIV   = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic             sign_q, sign_d;
    logic [EW-1:0]    exp_q, exp_d;
    logic [MAN_W:0]   mb_q, mb_d;
    logic [MAN_W+1:0] rem_q, rem_d;
    logic [MAN_W+2:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             special_q, special_d;
    logic [W-1:0]     spec_res_q, spec_res_d;
    logic [4:0]       spec_flags_q, spec_flags_d;
    logic [W-1:0]     result_q, result_d;
    logic [4:0]       flags_q, flags_d;

    // Operand unpacking (from the latched operands)
    logic             sa, sb, sgn;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, prep_special;

    assign {sa, ea, fa} = a_q;
    assign {sb, eb, fb} = b_q;
    assign sgn    = sa ^ sb;
    // A zero exponent field is treated as zero whatever the fraction holds.
    // This flushes subnormal inputs.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign prep_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

    // Divide-step and rounding temporaries
    logic             div_ge;
    logic [MAN_W+1:0] div_diff;
    logic [MAN_W-1:0] frac_pre, frac_r;
    logic             guard, rnd, sticky, round_up, carry;
    logic [EW-1:0]    e_adj, e_fin;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_PREP;
            // Special results pass through ROUND. The result register is then
            // written only on the edge that enters DONE, as on the normal path.
            S_PREP:  state_d = prep_special ? S_ROUND : S_DIV;
            S_DIV:   if (cnt_q == CNT_LAST) state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    assign result  = result_q;
    assign flags   = flags_q;
    assign state_o = state_q;

    // ---------------- datapath next-state ----------------
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        sign_d       = sign_q;
        exp_d        = exp_q;
        mb_d         = mb_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        cnt_d        = cnt_q;
        special_d    = special_q;
        spec_res_d   = spec_res_q;
        spec_flags_d = spec_flags_q;
        result_d     = result_q;
        flags_d      = flags_q;

        // Restoring step: subtract the divisor when it fits.
        div_ge   = (rem_q >= {1'b0, mb_q});
        div_diff = div_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

        // Normalise: if the quotient is below 1, take one more fraction bit.
        // In that case the round position holds a shifted-in zero.
        if (quo_q[MAN_W+2]) begin
            frac_pre = quo_q[MAN_W+1:2];
            guard    = quo_q[1];
            rnd      = quo_q[0];
            e_adj    = exp_q;
        end else begin
            frac_pre = quo_q[MAN_W:1];
            guard    = quo_q[0];
            rnd      = 1'b0;
            e_adj    = exp_q - EW'(1);
        end
        sticky   = (rem_q != '0);
        round_up = guard & (rnd | sticky | frac_pre[0]);
        // The hidden one is always set. A carry out of the fraction therefore
        // means the mantissa rolled over to 10.0. The fraction is then zero
        // and the exponent goes up by one.
        {carry, frac_r} = {1'b0, frac_pre} + {{MAN_W{1'b0}}, round_up};
        e_fin = carry ? (e_adj + EW'(1)) : e_adj;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = a;
                    b_d = b;
                end
            end
            S_PREP: begin
                sign_d       = sgn;
                exp_d        = EW'(ea) - EW'(eb) + BIAS_E;
                mb_d         = {1'b1, fb};
                rem_d        = {2'b01, fa};
                quo_d        = '0;
                cnt_d        = '0;
                special_d    = prep_special;
                spec_flags_d = '0;
                spec_res_d   = {sgn, {(W-1){1'b0}}};
                if (a_nan || b_nan) begin
                    spec_res_d = QNAN;
                end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                    spec_res_d   = QNAN;
                    spec_flags_d = FL_INV;
                end else if (b_zero) begin
                    // Dividing inf by zero gives inf with no flag.
                    spec_res_d = {sgn, EXP_ONES, {MAN_W{1'b0}}};
                    if (!a_inf) spec_flags_d = FL_DBZ;
                end else if (a_inf) begin
                    spec_res_d = {sgn, EXP_ONES, {MAN_W{1'b0}}};
                end
                // The remaining cases (0/x and x/inf) keep the signed-zero default.
            end
            S_DIV: begin
                rem_d = div_diff << 1;
                quo_d = {quo_q[MAN_W+1:0], div_ge};
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_ROUND: begin
                if (special_q) begin
                    result_d = spec_res_q;
                    flags_d  = spec_flags_q;
                end else if (!e_fin[EW-1] && (e_fin >= EMAX)) begin
                    result_d = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
                    flags_d  = FL_OVF | FL_INX;
                end else if (e_fin[EW-1] || (e_fin == '0)) begin
                    result_d = {sign_q, {(W-1){1'b0}}};
                    flags_d  = FL_UNF | FL_INX;
                end else begin
                    result_d = {sign_q, e_fin[EXP_W-1:0], frac_r};
                    flags_d  = (guard | rnd | sticky) ? FL_INX : 5'b00000;
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            mb_q         <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            cnt_q        <= '0;
            special_q    <= 1'b0;
            spec_res_q   <= '0;
            spec_flags_q <= '0;
            result_q     <= '0;
            flags_q      <= '0;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            mb_q         <= mb_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            cnt_q        <= cnt_d;
            special_q    <= special_d;
            spec_res_q   <= spec_res_d;
            spec_flags_q <= spec_flags_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
        end
    end

endmodule

// File: tb/tb_float_div_seq.sv
// ---------------------------------------------------------------------------
// tb_float_div_seq
//   Directed testbench for the fp16 configuration of float_div_seq. Every
//   expected value below was worked out by hand from the operand encodings.
// ---------------------------------------------------------------------------
module tb_float_div_seq;

    localparam int W = 16;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_INV  = 5'b10000;
    localparam logic [4:0] F_DBZ  = 5'b01000;
    localparam logic [4:0] F_OVF  = 5'b00100;
    localparam logic [4:0] F_UNF  = 5'b00010;
    localparam logic [4:0] F_INX  = 5'b00001;

    localparam int LAT_NORMAL  = 15;
    localparam int LAT_SPECIAL = 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [4:0]   flags;
    logic [2:0]   state_o;

    int errors = 0;
    int checks = 0;

    float_div_seq #(.EXP_W(5), .MAN_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .state_o   (state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands. On return the accepting edge (E0) has just passed.
    task automatic start_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check({tag, "_in_ready_before"}, in_ready, 1'b1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a        = $urandom_range(0, 16'hFFFF);
        b        = $urandom_range(0, 16'hFFFF);
    endtask

    // Count edges after E0 until out_valid. Also check that in_ready stayed low.
    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        logic saw_ready;
        n = 0;
        saw_ready = 1'b0;
        while (out_valid !== 1'b1 && n < 100) begin
            if (in_ready !== 1'b0) saw_ready = 1'b1;
            step();
            n++;
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_in_ready_busy"}, saw_ready, 1'b0);
    endtask

    // Check the result and flags, then complete the output handshake.
    task automatic take(input string tag, input logic [W-1:0] exp_res, input logic [4:0] exp_fl);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_flags"}, flags, exp_fl);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, in_ready, 1'b1);
        check({tag, "_out_valid_after"}, out_valid, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_res, input logic [4:0] exp_fl, input int exp_lat);
        start_op(tag, av, bv);
        wait_valid(tag, exp_lat);
        take(tag, exp_res, exp_fl);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 16'h0000);
        check("rst_flags", flags, F_NONE);
        check("rst_state", state_o, 3'd0);
        rst_n = 1'b1;
        step();

        // Normal path
        run_op("one_div_two",   16'h3C00, 16'h4000, 16'h3800, F_NONE, LAT_NORMAL);
        run_op("one_div_three", 16'h3C00, 16'h4200, 16'h3555, F_INX,  LAT_NORMAL);
        run_op("six_div_m2",    16'h4600, 16'hC000, 16'hC200, F_NONE, LAT_NORMAL);

        // Special operands
        run_op("x_div_zero",    16'h3C00, 16'h0000, 16'h7C00, F_DBZ,  LAT_SPECIAL);
        run_op("zero_div_zero", 16'h0000, 16'h0000, 16'h7E00, F_INV,  LAT_SPECIAL);
        run_op("inf_div_inf",   16'h7C00, 16'h7C00, 16'h7E00, F_INV,  LAT_SPECIAL);
        run_op("nan_div_one",   16'h7E01, 16'h3C00, 16'h7E00, F_NONE, LAT_SPECIAL);

        // Range limits
        run_op("overflow",      16'h7BFF, 16'h0400, 16'h7C00, F_OVF | F_INX, LAT_NORMAL);
        run_op("underflow",     16'h0400, 16'h4000, 16'h0000, F_UNF | F_INX, LAT_NORMAL);
        run_op("subnormal_in",  16'h8001, 16'h3C00, 16'h8000, F_NONE, LAT_SPECIAL);

        // Backpressure: hold out_ready low for 5 cycles.
        start_op("bp", 16'h3C00, 16'h4000);
        wait_valid("bp", LAT_NORMAL);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_result", result, 16'h3800);
            check("bp_hold_flags", flags, F_NONE);
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_in_ready", in_ready, 1'b0);
        end
        take("bp", 16'h3800, F_NONE);

        // Back-to-back: operands accepted on the first edge with in_ready high.
        a        = 16'h4000;
        b        = 16'h3C00;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("b2b_accepted", in_ready, 1'b0);
        wait_valid("b2b", LAT_NORMAL - 1 + 1);
        take("b2b", 16'h4000, F_NONE);

        // Reset pulse while the divider is in DIV.
        start_op("mid_rst", 16'h3C00, 16'h4200);
        repeat (3) step();
        check("mid_rst_in_div", state_o, 3'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_result", result, 16'h0000);
        check("mid_rst_flags", flags, F_NONE);
        check("mid_rst_state", state_o, 3'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_out_valid", out_valid, 1'b0);
        run_op("post_rst", 16'h4000, 16'h3C00, 16'h4000, F_NONE, LAT_NORMAL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
